// File: rtl/key_conditioner_if.sv
// Raw push-button inputs and conditioned key pulses exchanged between the buttons and
// the Morse decoder.
interface key_conditioner_if;
    logic long_key_raw;
    logic short_key_raw;
    logic send_raw;
    logic back_space_raw;
    logic long_key_p;
    logic short_key_p;
    logic send_p;
    logic back_space_p;
    logic key_active;

    modport master (
        output long_key_raw,
        output short_key_raw,
        output send_raw,
        output back_space_raw,
        input  long_key_p,
        input  short_key_p,
        input  send_p,
        input  back_space_p,
        input  key_active
    );

    modport slave (
        input  long_key_raw,
        input  short_key_raw,
        input  send_raw,
        input  back_space_raw,
        output long_key_p,
        output short_key_p,
        output send_p,
        output back_space_p,
        output key_active
    );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises, debounces and arbitrates four push-buttons into exclusive one-cycle pulses.
// Define BACKSPACE_REPEAT_EN to enable back_space auto-repeat while it is held.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input logic              check,
    input logic              reset,
    key_conditioner_if.slave bus
);
    // Key index doubles as priority: higher index wins simultaneous presses.
    localparam int unsigned NumKeys = 4;
    localparam int unsigned BsIdx   = 3;
    localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StOwner, StSwallowed} state_e;

    logic [NumKeys-1:0] raw;
    logic [NumKeys-1:0] sync1_q;
    logic [NumKeys-1:0] s_q;
    logic [NumKeys-1:0] stable_q, stable_d;
    logic [NumKeys-1:0] rise, fall, higher_rise;
    logic [NumKeys-1:0] pulse_q, pulse_d;
    logic [CntW-1:0]    cnt_q [NumKeys];
    logic [CntW-1:0]    cnt_d [NumKeys];
    state_e             state_q [NumKeys];
    state_e             state_d [NumKeys];
    logic               any_held;
    logic               key_active_q;

    assign raw = {bus.back_space_raw, bus.send_raw, bus.long_key_raw, bus.short_key_raw};

    always_ff @(posedge check) begin
        if (reset) begin
            sync1_q      <= '0;
            s_q          <= '0;
            stable_q     <= '0;
            pulse_q      <= '0;
            key_active_q <= 1'b0;
            for (int k = 0; k < NumKeys; k++) begin
                cnt_q[k]   <= '0;
                state_q[k] <= StIdle;
            end
        end else begin
            sync1_q      <= raw;
            s_q          <= sync1_q;
            stable_q     <= stable_d;
            pulse_q      <= pulse_d;
            key_active_q <= |stable_q;
            for (int k = 0; k < NumKeys; k++) begin
                cnt_q[k]   <= cnt_d[k];
                state_q[k] <= state_d[k];
            end
        end
    end

    // Any sample agreeing with the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        fall     = '0;
        for (int k = 0; k < NumKeys; k++) begin
            cnt_d[k] = '0;
            if (s_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CntMax) begin
                    stable_d[k] = s_q[k];
                    rise[k]     = s_q[k];
                    fall[k]     = ~s_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        higher_rise = '0;
        for (int k = 0; k < NumKeys; k++) begin
            higher_rise[k] = |(rise >> (k + 1));
        end
    end

`ifdef BACKSPACE_REPEAT_EN
    localparam int unsigned RepMaxVal = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                         : REPEAT_PERIOD;
    localparam int unsigned RepW = $clog2(RepMaxVal + 1);
    localparam logic [RepW-1:0] RepDelayM1  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepPeriodM1 = RepW'(REPEAT_PERIOD - 1);
    localparam logic [RepW-1:0] RepSat      = {RepW{1'b1}};

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_first_q, rep_first_d;

    always_ff @(posedge check) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    always_comb begin
        pulse_d  = '0;
        any_held = 1'b0;
        for (int k = 0; k < NumKeys; k++) begin
            any_held = any_held | (state_q[k] != StIdle);
        end
        for (int k = 0; k < NumKeys; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                StIdle: begin
                    if (rise[k]) begin
                        if (!any_held && !higher_rise[k]) begin
                            state_d[k] = StOwner;
                            pulse_d[k] = 1'b1;
                        end else begin
                            state_d[k] = StSwallowed;
                        end
                    end
                end
                StOwner, StSwallowed: begin
                    if (fall[k]) state_d[k] = StIdle;
                end
                default: state_d[k] = StIdle;
            endcase
        end
`ifdef BACKSPACE_REPEAT_EN
        rep_cnt_d   = '0;
        rep_first_d = rep_first_q;
        if (pulse_d[BsIdx]) begin
            rep_first_d = 1'b1;
        end else if (state_q[BsIdx] == StOwner && !fall[BsIdx]) begin
            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; cleared on each pulse.
            if (rep_cnt_q == (rep_first_q ? RepDelayM1 : RepPeriodM1)) begin
                pulse_d[BsIdx] = 1'b1;
                rep_first_d    = 1'b0;
            end else if (rep_cnt_q != RepSat) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q;
            end
        end
`endif
    end

    assign bus.short_key_p  = pulse_q[0];
    assign bus.long_key_p   = pulse_q[1];
    assign bus.send_p       = pulse_q[2];
    assign bus.back_space_p = pulse_q[BsIdx];
    assign bus.key_active   = key_active_q;
endmodule
